// File: rtl/alu_op_sequencer.sv
// ALU operand/select initiator: latency SETTLE_CYCLES+1 (divide-by-zero 1), cmd_ready low until rsp handshake.
// Optional statistics counters under `ALU_SEQ_STATS_EN (stat_ops, stat_errs).
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_select,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_errs
`endif
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES must be >= 1");
  end

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          accept, div_zero, drive_last, rsp_hs;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign div_zero  = (cmd_op == 4'b0011) && (cmd_b == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    drive_last = 1'b0;
    rsp_hs     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = div_zero ? RESP : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == LAST) begin
          drive_last = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rejected commands never reach the ALU, so its inputs keep the last legal operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        rsp_tag <= cmd_tag;
        if (div_zero) begin
          rsp_data  <= 8'hFF;
          rsp_carry <= 1'b0;
          rsp_err   <= 1'b1;
        end else begin
          alu_a      <= cmd_a;
          alu_b      <= cmd_b;
          alu_select <= cmd_op;
        end
      end
      if (state_q == DRIVE) begin
        cnt_q <= cnt_q + 1'b1;
        if (drive_last) begin
          rsp_data  <= alu_result;
          rsp_carry <= (alu_select == 4'b0000) && alu_carry;
          rsp_err   <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 1'b1;
      if (rsp_err && (stat_errs != '1)) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU downstream.
// Second instance with SETTLE_CYCLES=3 covers longer settle and reset mid-operation.
module tb_alu_op_sequencer;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (SETTLE_CYCLES=1)
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_op = '0, cmd_tag = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_select;
  logic       alu_carry;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_data;
  logic [3:0] rsp_tag;

  // second instance (SETTLE_CYCLES=3)
  logic       rst3 = 1'b1;
  logic       c3_valid = 1'b0, c3_ready;
  logic [7:0] c3_a = '0, c3_b = '0;
  logic [3:0] c3_op = '0, c3_tag = '0;
  logic [7:0] c3_alu_a, c3_alu_b, c3_alu_result;
  logic [3:0] c3_sel;
  logic       c3_alu_carry;
  logic       c3_rsp_valid, c3_rsp_ready = 1'b1, c3_rsp_carry, c3_rsp_err, c3_busy;
  logic [7:0] c3_rsp_data;
  logic [3:0] c3_rsp_tag;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_errs, c3_stat_ops, c3_stat_errs;
`endif

  // Downstream ALU: carry is always the carry of a+b.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0: r = s[7:0];
      4'd1: r = a - b;
      4'd2: r = 8'(a * b);
      4'd3: r = (b == 8'h00) ? 8'hFF : a / b;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      default: r = a;
    endcase
    return {s[8], r};
  endfunction

  assign {alu_carry, alu_result}       = alu_fn(alu_select, alu_a, alu_b);
  assign {c3_alu_carry, c3_alu_result} = alu_fn(c3_sel, c3_alu_a, c3_alu_b);

  alu_op_sequencer #(.SETTLE_CYCLES(S1), .TAG_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .busy(busy)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYCLES(S3), .TAG_W(4), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst3),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_a(c3_a), .cmd_b(c3_b), .cmd_op(c3_op), .cmd_tag(c3_tag),
    .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_select(c3_sel),
    .alu_result(c3_alu_result), .alu_carry(c3_alu_carry),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready),
    .rsp_data(c3_rsp_data), .rsp_carry(c3_rsp_carry), .rsp_err(c3_rsp_err), .rsp_tag(c3_rsp_tag),
    .busy(c3_busy)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(c3_stat_ops), .stat_errs(c3_stat_errs)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: pending command, expected response, last issued ALU inputs.
  logic [7:0] p_a, p_b, e_data, ea = '0, eb = '0;
  logic [3:0] p_op, p_tag, e_tag, esel = '0;
  logic       e_carry, e_err;
  int         e_lat;
  int         n_ops = 0, n_errs = 0;

  task automatic start_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [3:0] tag);
    p_a = a; p_b = b; p_op = op; p_tag = tag;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e_tag = p_tag;
    if (p_op == 4'd3 && p_b == 8'h00) begin
      e_data = 8'hFF; e_carry = 1'b0; e_err = 1'b1; e_lat = 1;
    end else begin
      logic [8:0] r;
      r = alu_fn(p_op, p_a, p_b);
      e_data = r[7:0]; e_carry = (p_op == 4'd0) ? r[8] : 1'b0; e_err = 1'b0; e_lat = S1 + 1;
      ea = p_a; eb = p_b; esel = p_op;
    end
  endtask

  task automatic wait_rsp();
    int lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, e_lat);
    check("rsp_data", rsp_data, e_data);
    check("rsp_carry", rsp_carry, e_carry);
    check("rsp_err", rsp_err, e_err);
    check("rsp_tag", rsp_tag, e_tag);
    check("alu_in", {alu_select, alu_a, alu_b}, {esel, ea, eb});
    check("busy_resp", {busy, cmd_ready}, 2'b10);
  endtask

  task automatic finish_rsp(input int stall);
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_hold", {rsp_valid, cmd_ready, rsp_err, rsp_tag, rsp_data},
            {1'b1, 1'b0, e_err, e_tag, e_data});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_hs", {rsp_valid, cmd_ready, busy}, 3'b010);
    n_ops++;
    if (e_err) n_errs++;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [3:0] tag, input int stall);
    start_cmd(a, b, op, tag);
    wait_accept();
    wait_rsp();
    finish_rsp(stall);
  endtask

  initial begin
    int lat;
    logic seen;
    repeat (2) @(negedge clk);
    check("reset_state", {cmd_ready, rsp_valid, busy, alu_a, alu_select, rsp_data, rsp_err},
          {1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0});
    rst = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    issue(8'h0F, 8'h01, 4'b0000, 4'd3, 0);
    issue(8'hFF, 8'h01, 4'b0000, 4'd4, 1);
    issue(8'hFF, 8'h01, 4'b0001, 4'd5, 0);
    issue(8'h20, 8'h00, 4'b0011, 4'd6, 1);

    // response backpressure with a second command already waiting
    start_cmd(8'h33, 8'h11, 4'b0110, 4'd8);
    wait_accept();
    wait_rsp();
    start_cmd(8'h40, 8'h05, 4'b0000, 4'd9);
    finish_rsp(5);
    wait_accept();
    wait_rsp();
    finish_rsp(0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      issue(ra, rb, 4'($urandom_range(0, 7)), 4'($urandom), int'($urandom_range(0, 3)));
    end

    // SETTLE_CYCLES=3 instance: latency, then reset during DRIVE
    c3_a = 8'h12; c3_b = 8'h34; c3_op = 4'd0; c3_tag = 4'd7; c3_valid = 1'b1;
    @(posedge clk);
    #1 c3_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!c3_rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("s3_latency", lat, S3 + 1);
    check("s3_rsp", {c3_rsp_data, c3_rsp_carry, c3_rsp_err, c3_rsp_tag}, {8'h46, 1'b0, 1'b0, 4'd7});
    @(negedge clk);
    check("s3_idle", {c3_ready, c3_rsp_valid}, 2'b10);
    c3_a = 8'h05; c3_b = 8'h06; c3_op = 4'd2; c3_tag = 4'd1; c3_valid = 1'b1;
    @(posedge clk);
    #1 c3_valid = 1'b0;
    @(negedge clk);
    check("s3_drive", {c3_busy, c3_ready, c3_alu_a, c3_sel}, {1'b1, 1'b0, 8'h05, 4'd2});
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    check("s3_abort", {c3_ready, c3_busy, c3_rsp_valid, c3_alu_a, c3_sel, c3_rsp_data},
          {1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00});
    @(negedge clk);
    rst3 = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (c3_rsp_valid) seen = 1'b1;
    end
    check("s3_no_rsp_after_reset", seen, 1'b0);

`ifdef ALU_SEQ_STATS_EN
    check("stat_ops", stat_ops, n_ops);
    check("stat_errs", stat_errs, n_errs);
    check("s3_stats_reset", {c3_stat_ops, c3_stat_errs}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
